// File: rtl/ising_stream_pkg.sv
// Shared types and helpers for the spin readout streaming path.
package ising_stream_pkg;

    localparam int SEQ_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, HDR, DATA} stream_state_e;

    function automatic int words_per_frame(input int num_spins, input int word_w);
        return (num_spins + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/spin_frame_fifo.sv
// Register-based frame FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module spin_frame_fifo #(
    parameter int W     = 58,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     push_ok_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count_o   = wr_q - rd_q;
    assign full_o    = (count_o == FULL_CNT);
    assign empty_o   = (count_o == '0);
    assign do_pop    = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || do_pop);
    assign rdata_o   = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok_o) wr_d = wr_q + 1'b1;
            if (do_pop)    rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o && !clear_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spin_readout_streamer.sv
// Buffers sequence-tagged spin snapshots and serialises them as header + data words over valid/ready.
module spin_readout_streamer
    import ising_stream_pkg::*;
#(
    parameter int NUM_SPINS = 50,
    parameter int WORD_W    = 8,
    parameter int DEPTH     = 16,
    parameter int HDR_EN    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_sample,
    input  logic [NUM_SPINS-1:0]    i_spin_read_out,
    input  logic                    i_stream_en,
    output logic [WORD_W-1:0]       o_word,
    output logic                    o_word_valid,
    input  logic                    i_word_ready,
    output logic                    o_oe_n,
    output logic                    o_ie,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow,
    output logic                    o_busy
);
    localparam int WPF = words_per_frame(NUM_SPINS, WORD_W);
    localparam int SRW = WPF * WORD_W;
    localparam int IW  = $clog2(WPF + 1);
    localparam int HB  = (WORD_W < SEQ_W) ? WORD_W : SEQ_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(WPF - 1);

    stream_state_e              state_q, state_d;
    logic [SEQ_W-1:0]           seq_q, seq_d, fseq_q, fseq_d;
    logic [SRW-1:0]             sr_q, sr_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       ovf_q, ovf_d;
    logic                       push, push_ok, pop;
    logic [SEQ_W+NUM_SPINS-1:0] rdata;
    logic [WORD_W-1:0]          hdr_word;

    assign push = i_sample && !i_clear;

    spin_frame_fifo #(.W(SEQ_W + NUM_SPINS), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .clear_i   (i_clear),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   ({seq_q, i_spin_read_out}),
        .rdata_o   (rdata),
        .push_ok_o (push_ok),
        .count_o   (o_count),
        .full_o    (o_full),
        .empty_o   (o_empty)
    );

    always_comb begin
        hdr_word = '0;
        for (int b = 0; b < HB; b++) hdr_word[b] = fseq_q[b];
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        fseq_d  = fseq_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (i_stream_en && !o_empty) state_d = LOAD;
            LOAD: begin
                pop                   = 1'b1;
                fseq_d                = rdata[NUM_SPINS +: SEQ_W];
                sr_d                  = '0;
                sr_d[NUM_SPINS-1:0]   = rdata[NUM_SPINS-1:0];
                idx_d                 = '0;
                state_d               = (HDR_EN != 0) ? HDR : DATA;
            end
            HDR: if (i_word_ready) state_d = DATA;
            DATA: if (i_word_ready) begin
                sr_d  = sr_q >> WORD_W;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX)
                    state_d = (i_stream_en && !o_empty) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_clear) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // Sequence advances on every sample, accepted or dropped, so gaps show up in headers.
    always_comb begin
        seq_d = seq_q;
        ovf_d = ovf_q;
        if (i_clear) begin
            seq_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (i_sample)           seq_d = seq_q + 1'b1;
            if (push && !push_ok)   ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            seq_q   <= '0;
            fseq_q  <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            fseq_q  <= fseq_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_word_valid = (state_q == HDR) || (state_q == DATA);
    assign o_word       = (state_q == HDR)  ? hdr_word :
                          (state_q == DATA) ? sr_q[WORD_W-1:0] : '0;
    assign o_busy       = (state_q != IDLE);
    assign o_oe_n       = !o_busy;
    assign o_ie         = !o_busy;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_spin_readout_streamer.sv
// Self-checking bench: directed corner cases, a status table, and randomized traffic against a frame-level model.
module tb_spin_readout_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (50 spins, 8-bit words, header)
    logic        rst, clr, smp, en, rdy;
    logic [49:0] spins;
    logic [7:0]  w;
    logic        wv, oen, ie, full, empty, ovf, busy;
    logic [4:0]  cnt;

    // parameter sweep instances share these inputs
    logic        s_smp, s_en, s_rdy, s_clr;
    logic [63:0] s_sp;
    logic [15:0] w1, w2;
    logic        v1, v2, oen1, ie1, full1, empty1, ovf1, busy1, oen2, ie2, full2, empty2, ovf2, busy2;
    logic [2:0]  cnt1, cnt2;

    spin_readout_streamer dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_sample(smp), .i_spin_read_out(spins),
        .i_stream_en(en), .o_word(w), .o_word_valid(wv), .i_word_ready(rdy), .o_oe_n(oen),
        .o_ie(ie), .o_count(cnt), .o_full(full), .o_empty(empty), .o_overflow(ovf), .o_busy(busy));

    spin_readout_streamer #(.NUM_SPINS(64), .WORD_W(16), .DEPTH(4), .HDR_EN(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_clear(s_clr), .i_sample(s_smp), .i_spin_read_out(s_sp),
        .i_stream_en(s_en), .o_word(w1), .o_word_valid(v1), .i_word_ready(s_rdy), .o_oe_n(oen1),
        .o_ie(ie1), .o_count(cnt1), .o_full(full1), .o_empty(empty1), .o_overflow(ovf1), .o_busy(busy1));

    spin_readout_streamer #(.NUM_SPINS(50), .WORD_W(16), .DEPTH(4), .HDR_EN(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_clear(s_clr), .i_sample(s_smp), .i_spin_read_out(s_sp[49:0]),
        .i_stream_en(s_en), .o_word(w2), .o_word_valid(v2), .i_word_ready(s_rdy), .o_oe_n(oen2),
        .o_ie(ie2), .o_count(cnt2), .o_full(full2), .o_empty(empty2), .o_overflow(ovf2), .o_busy(busy2));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Frame-level reference: every accepted snapshot becomes header + 7 bytes in the expected stream.
    typedef struct { logic [7:0] w; bit last; } ew_t;
    ew_t         expq[$];
    logic [7:0]  logq[$];
    logic [15:0] q1[$], q2[$];
    int          acc_n = 0, done_n = 0;
    logic [7:0]  mseq = 8'h00;
    bit          mov = 1'b0;

    function automatic bit room();
        return (acc_n - done_n) < 16;
    endfunction

    task automatic m_sample(input logic [49:0] sp, input bit acc);
        logic [55:0] p;
        if (acc) begin
            p = {6'b0, sp};
            expq.push_back('{w: mseq, last: 1'b0});
            for (int k = 0; k < 7; k++) expq.push_back('{w: p[k*8 +: 8], last: (k == 6)});
            acc_n++;
        end else begin
            mov = 1'b1;
        end
        mseq = mseq + 8'd1;
    endtask

    task automatic m_clear();
        expq.delete();
        acc_n = 0; done_n = 0; mseq = 8'h00; mov = 1'b0;
    endtask

    task automatic mon(input logic [7:0] word);
        ew_t e;
        logq.push_back(word);
        checks++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word actual=%0h required=none", word);
        end else begin
            e = expq.pop_front();
            if (word !== e.w) begin
                fails++;
                $display("FAIL stream_word actual=%0h required=%0h", word, e.w);
            end
            if (e.last) done_n++;
        end
    endtask

    // One clock: handshake sampled mid-cycle, inputs may be changed on return (1 time unit after the edge).
    task automatic cyc();
        logic a0, a1, a2;
        logic [7:0] x0;
        logic [15:0] x1, x2;
        @(negedge clk);
        a0 = wv && rdy; x0 = w;
        a1 = v1 && s_rdy; x1 = w1;
        a2 = v2 && s_rdy; x2 = w2;
        @(posedge clk); #1;
        if (a0) mon(x0);
        if (a1) q1.push_back(x1);
        if (a2) q2.push_back(x2);
    endtask

    task automatic samp(input logic [49:0] sp, input bit acc);
        smp = 1'b1; spins = sp;
        m_sample(sp, acc);
        cyc();
        smp = 1'b0;
    endtask

    task automatic wait_words(input string nm, input int n, input int budget);
        int t = 0;
        while (logq.size() < n && t < budget) begin cyc(); t++; end
        chk(nm, logq.size(), n);
    endtask

    task automatic drain(input string nm, input int budget);
        int t = 0;
        en = 1'b1; rdy = 1'b1;
        while ((expq.size() != 0 || busy) && t < budget) begin cyc(); t++; end
        chk(nm, expq.size(), 0);
    endtask

    function automatic logic [49:0] rnd50();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[49:0];
    endfunction

    typedef struct { bit smp; bit clr; int cnt; bit full; bit empty; bit ovf; } vec_t;
    vec_t tbl[19];

    logic [7:0] frame0 [8];
    logic [7:0] held;

    initial begin
        tbl[0] = '{smp: 0, clr: 1, cnt: 0, full: 0, empty: 1, ovf: 0};
        for (int i = 1; i <= 17; i++)
            tbl[i] = '{smp: 1, clr: 0, cnt: (i > 16) ? 16 : i, full: (i >= 16), empty: 0, ovf: (i > 16)};
        tbl[18] = '{smp: 0, clr: 0, cnt: 16, full: 1, empty: 0, ovf: 1};
        frame0 = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

        rst = 1'b1; clr = 0; smp = 0; en = 0; rdy = 0; spins = '0;
        s_smp = 0; s_en = 0; s_rdy = 0; s_clr = 0; s_sp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", int'(w), 0);      chk("rst_valid", int'(wv), 0);
        chk("rst_oe_n", int'(oen), 1);    chk("rst_ie", int'(ie), 1);
        chk("rst_count", int'(cnt), 0);   chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1); chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc();

        // parameter sweep: 64/16 no header, 50/16 no header
        s_sp = 64'h0123_4567_89AB_CDEF; s_smp = 1'b1;
        cyc();
        s_smp = 1'b0; s_en = 1'b1; s_rdy = 1'b1;
        repeat (10) cyc();
        chk("sw64_nwords", q1.size(), 4);
        chk("sw50_nwords", q2.size(), 4);
        if (q1.size() == 4) begin
            chk("sw64_w0", int'(q1[0]), 'hCDEF); chk("sw64_w1", int'(q1[1]), 'h89AB);
            chk("sw64_w2", int'(q1[2]), 'h4567); chk("sw64_w3", int'(q1[3]), 'h0123);
        end
        if (q2.size() == 4) begin
            chk("sw50_w0", int'(q2[0]), 'hCDEF); chk("sw50_w1", int'(q2[1]), 'h89AB);
            chk("sw50_w2", int'(q2[2]), 'h4567); chk("sw50_w3", int'(q2[3]), 'h0003);
        end
        chk("sw_idle", int'(v1 | v2), 0);

        // single frame with latency and pad control
        logq.delete();
        samp(50'h2_0000_0000_0001, 1'b1);
        en = 1'b1; rdy = 1'b1;
        cyc();
        chk("load_busy", int'(busy), 1); chk("load_valid", int'(wv), 0);
        chk("load_oe_n", int'(oen), 0);  chk("load_ie", int'(ie), 0);
        cyc();
        chk("first_valid", int'(wv), 1); chk("first_word", int'(w), 0);
        wait_words("single_words", 8, 30);
        for (int i = 0; i < 8; i++) chk("single_frame", int'(logq[i]), int'(frame0[i]));
        chk("end_oe_n", int'(oen), 1); chk("end_ie", int'(ie), 1);
        chk("end_empty", int'(empty), 1); chk("end_busy", int'(busy), 0);

        // backpressure on the third word
        logq.delete();
        samp(rnd50(), room());
        wait_words("bp_pre", 2, 30);
        rdy = 1'b0; held = w;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", int'(wv), 1); chk("bp_hold", int'(w), int'(held));
        end
        rdy = 1'b1;
        wait_words("bp_words", 8, 30);
        chk("bp_model_empty", expq.size(), 0);

        // overflow table with streaming off
        en = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            smp = tbl[i].smp; clr = tbl[i].clr; spins = rnd50();
            if (tbl[i].clr) m_clear();
            else if (tbl[i].smp) m_sample(spins, room());
            cyc();
            smp = 1'b0; clr = 1'b0;
            chk("tbl_count", int'(cnt), tbl[i].cnt); chk("tbl_full", int'(full), int'(tbl[i].full));
            chk("tbl_empty", int'(empty), int'(tbl[i].empty)); chk("tbl_ovf", int'(ovf), int'(tbl[i].ovf));
        end
        logq.delete();
        drain("ovf_drain", 400);
        for (int i = 0; i < 16; i++) chk("ovf_hdr", int'(logq[i*8]), i);
        samp(rnd50(), room());
        drain("ovf_gap_drain", 40);
        chk("ovf_gap_hdr", int'(logq[128]), 'h11);
        chk("ovf_sticky", int'(ovf), 1);

        // clear mid-frame
        en = 1'b0;
        repeat (3) samp(rnd50(), room());
        en = 1'b1; rdy = 1'b1; logq.delete();
        wait_words("clr_pre", 2, 30);
        clr = 1'b1; rdy = 1'b0; m_clear();
        cyc();
        clr = 1'b0;
        chk("clr_valid", int'(wv), 0); chk("clr_oe_n", int'(oen), 1);
        chk("clr_count", int'(cnt), 0); chk("clr_ovf", int'(ovf), 0);
        logq.delete();
        samp(rnd50(), 1'b1);
        drain("clr_drain", 40);
        chk("clr_hdr", int'(logq[0]), 0);

        // full buffer, sample lands in the LOAD (pop) cycle
        en = 1'b0;
        repeat (16) samp(rnd50(), room());
        chk("sim_full", int'(full), 1);
        en = 1'b1; rdy = 1'b0;
        cyc();
        smp = 1'b1; spins = rnd50(); m_sample(spins, 1'b1);
        cyc();
        smp = 1'b0;
        chk("sim_ovf", int'(ovf), 0); chk("sim_count", int'(cnt), 16);
        drain("sim_drain", 600);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            en  = ($urandom_range(7) != 0);
            rdy = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0 && room()) begin
                smp = 1'b1; spins = rnd50(); m_sample(spins, 1'b1);
            end
            cyc();
            smp = 1'b0;
        end
        drain("rand_drain", 1200);
        chk("rand_count", int'(cnt), 0); chk("rand_empty", int'(empty), 1);
        chk("rand_ovf", int'(ovf), int'(mov));

        // asynchronous reset mid-DATA
        logq.delete();
        samp(50'h3_FFFF_FFFF_FFFF, room());
        en = 1'b1; rdy = 1'b1;
        wait_words("arst_pre", 2, 30);
        rdy = 1'b0;
        chk("arst_pre_word", int'(w), 'hFF);
        m_clear();
        rst = 1'b1;
        #1;
        chk("arst_word", int'(w), 0);      chk("arst_valid", int'(wv), 0);
        chk("arst_oe_n", int'(oen), 1);    chk("arst_ie", int'(ie), 1);
        chk("arst_count", int'(cnt), 0);   chk("arst_empty", int'(empty), 1);
        chk("arst_busy", int'(busy), 0);   chk("arst_full", int'(full), 0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
